// File: rtl/case_pkg.sv
// Shared types and ASCII constants for the streaming case converter.
package case_pkg;

  typedef enum logic [1:0] {
    PASS   = 2'b00,
    UPPER  = 2'b01,
    LOWER  = 2'b10,
    TOGGLE = 2'b11
  } case_mode_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_t;

  localparam logic [7:0] ASCII_UP_A  = 8'd65;
  localparam logic [7:0] ASCII_UP_Z  = 8'd90;
  localparam logic [7:0] ASCII_LO_A  = 8'd97;
  localparam logic [7:0] ASCII_LO_Z  = 8'd122;
  localparam logic [7:0] CASE_OFFSET = 8'd32;

endpackage

// File: rtl/case_convert_byte.sv
// Combinational single-byte case converter; flags whether the byte was altered.
module case_convert_byte
  import case_pkg::*;
(
  input  case_mode_t  mode,
  input  logic [7:0]  b,
  output logic [7:0]  y,
  output logic        changed
);

  logic is_up;
  logic is_lo;

  always_comb begin
    is_up = (b >= ASCII_UP_A) && (b <= ASCII_UP_Z);
    is_lo = (b >= ASCII_LO_A) && (b <= ASCII_LO_Z);
    y     = b;
    case (mode)
      UPPER:   if (is_lo) y = b - CASE_OFFSET;
      LOWER:   if (is_up) y = b + CASE_OFFSET;
      TOGGLE: begin
        if (is_lo)      y = b - CASE_OFFSET;
        else if (is_up) y = b + CASE_OFFSET;
      end
      default: y = b;
    endcase
    changed = (y != b);
  end

endmodule

// File: rtl/case_convert_stream.sv
// Streaming multi-lane case converter: per-packet mode lock, output register
// plus skid register for full throughput, saturating count of modified bytes.
module case_convert_stream
  import case_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_last,
  input  logic                 clr_count,
  output logic [CNT_W-1:0]     conv_count
);

  localparam int DW   = 8 * LANES;
  localparam int PC_W = $clog2(LANES + 1);

  pkt_state_t       state_q, state_d;
  case_mode_t       pkt_mode_q, pkt_mode_d, eff_mode;
  logic [DW-1:0]    conv_data;
  logic [LANES-1:0] lane_chg;
  logic [PC_W-1:0]  chg_cnt;

  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic             skid_last_q, skid_last_d;
  logic [DW-1:0]    skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer, out_xfer;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    if (sum[CNT_W]) return '1;
    return sum[CNT_W-1:0];
  endfunction

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  // The first beat of a packet uses the live mode; later beats use the latched one.
  assign eff_mode = (state_q == ST_IDLE) ? case_mode_t'(mode) : pkt_mode_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    case_convert_byte u_lane (
      .mode    (eff_mode),
      .b       (in_data[8*k +: 8]),
      .y       (conv_data[8*k +: 8]),
      .changed (lane_chg[k])
    );
  end

  always_comb begin
    chg_cnt = '0;
    for (int k = 0; k < LANES; k++) chg_cnt = chg_cnt + PC_W'(lane_chg[k]);
  end

  always_comb begin
    state_d    = state_q;
    pkt_mode_d = pkt_mode_q;
    if (in_xfer) begin
      if (state_q == ST_IDLE) pkt_mode_d = case_mode_t'(mode);
      state_d = in_last ? ST_IDLE : ST_IN_PKT;
    end
  end

  // A full skid implies in_ready is low, so no input can arrive that cycle.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    if (skid_valid_q) begin
      if (out_ready) begin
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = conv_data;
        out_last_d  = in_last;
        out_valid_d = 1'b1;
      end else begin
        skid_data_d  = conv_data;
        skid_last_d  = in_last;
        skid_valid_d = 1'b1;
      end
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_count)    cnt_d = '0;
    else if (in_xfer) cnt_d = sat_add(cnt_q, chg_cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pkt_mode_q   <= PASS;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pkt_mode_q   <= pkt_mode_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
    skid_last_q <= skid_last_d;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign conv_count = cnt_q;

endmodule

// File: doc/case_convert_stream.md
# case_convert_stream

Streaming, parametrised successor to the combinational `toUpper` byte converter. It converts `LANES` ASCII bytes per beat under a per-packet mode: pass, upper, lower or toggle. A valid/ready handshake runs on both sides, with one registered pipeline stage plus a skid buffer for full throughput. It sits between the byte-stream source and the text sink, and keeps a saturating count of modified bytes for software.

## Interface
- `LANES`, default 4: bytes per beat, minimum 1.
- `CNT_W`, default 16: width of the modified-byte counter, minimum 4.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `mode`  in  2: 00 pass, 01 upper, 10 lower, 11 toggle. Sampled only on the first beat of a packet.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: block can accept a beat.
- `in_data`  in  8*LANES: lane k = bits [8k+7:8k].
- `in_last`  in  1: final beat of packet.
- `out_valid`  out  1: output beat valid.
- `out_ready`  in  1: sink accepts beat.
- `out_data`  out  8*LANES: converted lanes.
- `out_last`  out  1: forwarded `in_last`.
- `clr_count`  in  1: synchronous clear of `conv_count`.
- `conv_count`  out  CNT_W: saturating count of bytes whose value changed.

## Operation
- **Transfers.** An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- **Per-lane rule, applied to each byte b:**
  - upper: 97..122 → b−32.
  - lower: 65..90 → b+32.
  - toggle: either range is flipped.
  - pass: b unchanged.
  - All other values are unchanged in every mode, including 64, 91, 96, 123, 127 and 128..255.
- **Packet FSM:**
  - `IDLE`: the first accepted beat latches `mode` into `pkt_mode` and uses it. If `in_last`=0, go to `IN_PKT`; if `in_last`=1, stay in `IDLE`.
  - `IN_PKT`: beats use `pkt_mode`, and `mode` changes are ignored. An accepted beat with `in_last`=1 returns to `IDLE`.
- **Counter.**
  - On each input transfer, add the number of lanes whose byte changed (0..LANES).
  - Saturates at 2^CNT_W−1 and never wraps.
  - If `clr_count` and an increment occur in the same cycle, clear wins: the next value is 0.
- **Datapath.** One output register plus one skid register, each holding data, last and valid.
  - `in_ready` is registered and is deasserted only when the skid register is occupied.
  - Beats are never dropped, duplicated or reordered. `out_data`/`out_last` stay stable while `out_valid && !out_ready`.
- **Reset.** Asynchronous assertion clears all state: FSM → `IDLE`, both registers empty.

## Timing
- **Reset values while `rst`=1:**
  - `out_valid`=0, `out_data`=0, `out_last`=0.
  - `in_ready`=0.
  - `conv_count`=0, `pkt_mode`=00.
- **After reset.** `in_ready`=1 on the first rising edge after `rst` deasserts.
- **Latency.** A beat accepted at edge n appears with `out_valid`=1 after edge n, provided the output register is empty or drained at n.
- **Throughput.** 1 beat/cycle sustained while `out_ready`=1.
- **Backpressure.** With `out_ready`=0, accept at most 2 beats (output register + skid), then `in_ready`=0 from the next cycle. When `out_ready` rises, the skid beat moves into the output register and `in_ready` returns to 1 one cycle later.
- **Simultaneous input and output transfer** with the skid register empty: the output register reloads in the same edge, with no bubble.
- **Counter timing.** `conv_count` updates on the edge of the input transfer and is visible the following cycle.
- **Reset mid-packet.** Any in-flight beats are discarded. The FSM returns to `IDLE`, so the next beat re-samples `mode`.

## Structure
- **Package `case_pkg`:**
  - mode enum `case_mode_t` (PASS, UPPER, LOWER, TOGGLE);
  - constants for ASCII 'A'=65, 'Z'=90, 'a'=97, 'z'=122 and case offset 32;
  - FSM state enum.
- **Sub-module `case_convert_byte`:** combinational, ports `mode`, `b`, `y`, `changed`. Instantiate it once per lane in a generate loop; the per-lane `changed` outputs feed a popcount adder into the counter.
- **Top level:** FSM, skid/output registers and the saturating counter, about 200 lines.

## Test plan
- **Directed byte vectors.** LANES=4, mode=01, one beat {97,65,122,183}, last=1 → out {65,65,90,183}; conv_count=2.
- **Boundary bytes.** Boundary bytes {64,91,96,123}, {127,128,255,0} in each of the four modes → all unchanged; count unchanged. Then mode=11 on {72,109,48,90} → {104,77,48,122}; count +3.
- **Mode locked per packet.** Packet of 3 beats, mode=10 on beat 1, switched to 01 before beats 2 and 3 → all beats lowercased. The next packet uses 01.
- **Backpressure.** `out_ready`=0 with 4 beats offered → exactly 2 accepted and `in_ready`=0. Then `out_ready`=1 → beats emerge in order with stable data during the stall, and no loss or duplication.
- **Counter saturation and clear.** CNT_W=4, stream 5 beats of "aaaa" in upper mode → count saturates at 15. Assert `clr_count` together with a converting beat → count=0.
- **Reset mid-packet.** Assert `rst` with 2 beats buffered → `out_valid`=0 immediately (asynchronous) and `conv_count`=0. After release, the first beat samples the new `mode`.
